// File: rtl/usb_data_buffer_if.sv
// Bus bundle between the AHB slave / USB engines (master) and the shared byte buffer (slave).
interface usb_data_buffer_if;
  logic       clear;
  logic       store_tx_data;
  logic [7:0] tx_data;
  logic       get_rx_data;
  logic [7:0] rx_data;
  logic       store_rx_packet_data;
  logic [7:0] rx_packet_data;
  logic       get_tx_packet_data;
  logic [7:0] tx_packet_data;
  logic [6:0] buffer_occupancy;
  logic       buffer_empty;
  logic       buffer_full;
  logic       overflow_err;
  logic       underflow_err;

  modport master (
    output clear, store_tx_data, tx_data, get_rx_data,
    output store_rx_packet_data, rx_packet_data, get_tx_packet_data,
    input  rx_data, tx_packet_data, buffer_occupancy,
    input  buffer_empty, buffer_full, overflow_err, underflow_err
  );

  modport slave (
    input  clear, store_tx_data, tx_data, get_rx_data,
    input  store_rx_packet_data, rx_packet_data, get_tx_packet_data,
    output rx_data, tx_packet_data, buffer_occupancy,
    output buffer_empty, buffer_full, overflow_err, underflow_err
  );
endinterface

// File: rtl/usb_data_buffer.sv
// Byte FIFO shared by the AHB slave and USB RX/TX engines, first-word-fall-through reads.
// Sticky overflow/underflow flags are built only when BUFFER_ERR_FLAGS_EN is defined.
module usb_data_buffer #(
  parameter int DEPTH = 64
) (
  input logic              clk,
  input logic              rst,
  usb_data_buffer_if.slave bus
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0] DEPTH_C = 7'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [6:0]    occ_q, occ_d;
  logic          empty_q, full_q;

  logic          push_req, pop_req;
  logic          push_ok, pop_ok;
  logic [7:0]    push_byte;
  logic [7:0]    head_byte;

  // RX engine wins the write port; a full buffer still takes a push if a pop frees a slot.
  always_comb begin
    push_req  = bus.store_rx_packet_data | bus.store_tx_data;
    push_byte = bus.store_rx_packet_data ? bus.rx_packet_data : bus.tx_data;
    pop_req   = bus.get_tx_packet_data | bus.get_rx_data;
    pop_ok    = pop_req & ~empty_q & ~bus.clear;
    push_ok   = push_req & (~full_q | pop_ok) & ~bus.clear;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (bus.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   occ_d = occ_q + 7'd1;
        2'b01:   occ_d = occ_q - 7'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      empty_q  <= (occ_d == 7'd0);
      full_q   <= (occ_d == DEPTH_C);
    end
  end

  // Storage has no reset so it maps onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_byte;
  end

  assign head_byte            = empty_q ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.rx_data          = head_byte;
  assign bus.tx_packet_data   = head_byte;
  assign bus.buffer_occupancy = occ_q;
  assign bus.buffer_empty     = empty_q;
  assign bus.buffer_full      = full_q;

`ifdef BUFFER_ERR_FLAGS_EN
  logic ovf_q, unf_q;
  logic push_drop;

  // A dual push loses the AHB byte, which counts as a drop just like pushing into a full buffer.
  assign push_drop = (bus.store_rx_packet_data & bus.store_tx_data) | (push_req & ~push_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bus.clear) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push_drop)          ovf_q <= 1'b1;
      if (pop_req & empty_q)  unf_q <= 1'b1;
    end
  end

  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;
`else
  assign bus.overflow_err  = 1'b0;
  assign bus.underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_usb_data_buffer.sv
// Bench for usb_data_buffer: vector table plus queue scoreboard of expected buffer contents.
module tb_usb_data_buffer;
  localparam int DEPTH = 64;
`ifdef BUFFER_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_data_buffer_if bus_if ();

  usb_data_buffer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int errors = 0;
  int checks = 0;
  int txn    = 0;
  logic [7:0] sb[$];
  bit ovf_m = 1'b0;
  bit unf_m = 1'b0;

  typedef struct {
    bit         srx;
    logic [7:0] rxb;
    bit         stx;
    logic [7:0] txb;
    bit         gtx;
    bit         grx;
    bit         clr;
    int         exp_occ;
    bit         exp_ovf;
    bit         exp_unf;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (txn %0d): got %0h expected %0h", name, txn, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_if.clear                = 1'b0;
    bus_if.store_tx_data        = 1'b0;
    bus_if.tx_data              = 8'h00;
    bus_if.get_rx_data          = 1'b0;
    bus_if.store_rx_packet_data = 1'b0;
    bus_if.rx_packet_data       = 8'h00;
    bus_if.get_tx_packet_data   = 1'b0;
  endtask

  task automatic check_state();
    logic [7:0] head;
    head = (sb.size() > 0) ? sb[0] : 8'h00;
    chk("occupancy", 32'(bus_if.buffer_occupancy), 32'(sb.size()));
    chk("empty", 32'(bus_if.buffer_empty), 32'(sb.size() == 0));
    chk("full", 32'(bus_if.buffer_full), 32'(sb.size() == DEPTH));
    chk("overflow_err", 32'(bus_if.overflow_err), 32'(ovf_m & ERR_EN));
    chk("underflow_err", 32'(bus_if.underflow_err), 32'(unf_m & ERR_EN));
    chk("rx_data_head", 32'(bus_if.rx_data), 32'(head));
    chk("tx_packet_head", 32'(bus_if.tx_packet_data), 32'(head));
  endtask

  // Called at posedge+1: drives one cycle of requests, updates the reference queue, checks after the edge.
  task automatic step(input bit srx, input logic [7:0] rxb, input bit stx, input logic [7:0] txb,
                      input bit gtx, input bit grx, input bit clr);
    bit pop_req, pop_ok;
    bus_if.store_rx_packet_data = srx;
    bus_if.rx_packet_data       = rxb;
    bus_if.store_tx_data        = stx;
    bus_if.tx_data              = txb;
    bus_if.get_tx_packet_data   = gtx;
    bus_if.get_rx_data          = grx;
    bus_if.clear                = clr;
    pop_req = gtx | grx;
    pop_ok  = pop_req && (sb.size() > 0) && !clr;
    if (pop_ok) begin
      chk("pop_rx_data", 32'(bus_if.rx_data), 32'(sb[0]));
      chk("pop_tx_packet_data", 32'(bus_if.tx_packet_data), 32'(sb[0]));
    end
    if (clr) begin
      sb.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      if (srx && stx) ovf_m = 1'b1;
      if (pop_req && sb.size() == 0) unf_m = 1'b1;
      if (pop_ok) void'(sb.pop_front());
      if (srx || stx) begin
        if (sb.size() < DEPTH) sb.push_back(srx ? rxb : txb);
        else ovf_m = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    idle_inputs();
    txn++;
    $display("txn %0d: srx=%0b stx=%0b pop=%0b clr=%0b occ=%0d head=%02h", txn, srx, stx, pop_req, clr,
             bus_if.buffer_occupancy, bus_if.rx_data);
    check_state();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0};

    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_state();

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].srx, vecs[i].rxb, vecs[i].stx, vecs[i].txb, vecs[i].gtx, vecs[i].grx, vecs[i].clr);
      chk("vec_occupancy", 32'(bus_if.buffer_occupancy), 32'(vecs[i].exp_occ));
      chk("vec_overflow", 32'(bus_if.overflow_err), 32'(vecs[i].exp_ovf & ERR_EN));
      chk("vec_underflow", 32'(bus_if.underflow_err), 32'(vecs[i].exp_unf & ERR_EN));
    end

    // Fill to DEPTH from the RX engine, overflow once, drain through the TX side.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("fill_full", 32'(bus_if.buffer_full), 32'd1);
    step(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("full_drop_ovf", 32'(bus_if.overflow_err), 32'(ERR_EN));
    chk("full_drop_occ", 32'(bus_if.buffer_occupancy), 32'd64);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("drained_empty", 32'(bus_if.buffer_empty), 32'd1);
    step(1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    chk("wrap_head", 32'(bus_if.rx_data), 32'h5A);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Full with a simultaneous push and pop: both complete.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 8'(i) ^ 8'hA5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
    chk("full_pushpop_occ", 32'(bus_if.buffer_occupancy), 32'd64);
    chk("full_pushpop_ovf", 32'(bus_if.overflow_err), 32'd0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Occupancy 5 with a simultaneous push/pop; 8'hAA must come out fifth.
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    chk("pushpop_occ", 32'(bus_if.buffer_occupancy), 32'd5);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("aa_fifth", 32'(bus_if.rx_data), 32'hAA);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Clear wins over a same-cycle push; then a push does not satisfy a pop while empty.
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    chk("clear_occ", 32'(bus_if.buffer_occupancy), 32'd0);
    step(1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("empty_pushpop_occ", 32'(bus_if.buffer_occupancy), 32'd1);
    chk("empty_pushpop_unf", 32'(bus_if.underflow_err), 32'(ERR_EN));
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset pulsed between edges with occupancy 30.
    for (int i = 0; i < 30; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_occ", 32'(bus_if.buffer_occupancy), 32'd0);
    chk("async_rst_empty", 32'(bus_if.buffer_empty), 32'd1);
    chk("async_rst_rx_data", 32'(bus_if.rx_data), 32'h00);
    rst = 1'b0;
    sb.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    @(posedge clk);
    #1;
    check_state();
    step(1'b0, 8'h00, 1'b1, 8'h9C, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/usb_data_buffer.md
# usb_data_buffer

Byte-wide FIFO data buffer shared by the AHB-Lite slave and the USB protocol engines, sitting directly downstream of the slave's register/value block. It accepts bytes from the AHB write path (`store_tx_data`/`tx_data`) or the USB RX engine, and supplies bytes to the AHB read path (`get_rx_data`/`rx_data`) or the USB TX engine. It reports `buffer_occupancy` back to the slave and honours the slave's `clear` flush request.

## Interface
- `DEPTH`, 64, number of byte entries; power of two, 2..64.
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous, active-high; clears all state immediately.
- `clear`  input  1  synchronous flush request from the slave.
- `store_tx_data`  input  1  AHB-side push strobe, one byte per cycle.
- `tx_data`  input  8  AHB-side push byte.
- `get_rx_data`  input  1  AHB-side pop strobe.
- `rx_data`  output  8  head byte for the AHB side.
- `store_rx_packet_data`  input  1  USB RX push strobe.
- `rx_packet_data`  input  8  USB RX push byte.
- `get_tx_packet_data`  input  1  USB TX pop strobe.
- `tx_packet_data`  output  8  head byte for the USB TX side.
- `buffer_occupancy`  output  7  stored byte count, 0..DEPTH.
- `buffer_empty`  output  1  occupancy == 0.
- `buffer_full`  output  1  occupancy == DEPTH.
- `overflow_err`  output  1  sticky: a push was dropped.
- `underflow_err`  output  1  sticky: a pop was made while empty.

## Operation
- Circular storage: `DEPTH` x 8 memory, write pointer, read pointer, each log2(DEPTH) bits, wrapping DEPTH-1 -> 0. Occupancy is a separate 7-bit counter.
- Push arbitration, one push per cycle:
  - `store_rx_packet_data` has priority over `store_tx_data`.
  - When both are asserted, the RX byte is written, the AHB byte is dropped, and `overflow_err` is set.
- Pop arbitration, one pop per cycle:
  - `get_tx_packet_data` has priority over `get_rx_data`.
  - When both are asserted, only one byte is removed.
- Full: a push is dropped, the pointers are unchanged, and `overflow_err` is set.
  - Exception: a push and a pop in the same cycle while full both complete, and occupancy stays DEPTH.
- Empty: a pop is ignored, the pointers are unchanged, and `underflow_err` is set.
  - A same-cycle push does not satisfy a pop while empty.
- Push and pop accepted in the same cycle: both pointers advance and occupancy is unchanged.
- `clear` overrides all pushes and pops in that cycle. Next cycle: pointers 0, occupancy 0, both error flags 0.
- Read data is first-word-fall-through: `rx_data` and `tx_packet_data` both equal mem[rd_ptr] combinationally when occupancy > 0, else 8'h00.
- Error flags clear only on `clear` or `rst`.

## Timing
- Reset values: occupancy 0, `buffer_empty` 1, `buffer_full` 0, `rx_data`/`tx_packet_data` 8'h00, both error flags 0, pointers 0.
- Push: a byte pushed at edge N is visible on the read outputs after edge N when the buffer was empty.
- `buffer_occupancy`, `buffer_empty` and `buffer_full` are registered; they reflect all operations accepted at the previous edge.
- Pop: the next byte appears on the read outputs immediately after the popping edge.
- Reset asserted mid-operation: all state returns to its reset value asynchronously; memory contents are don't-care.

## Configuration
- `BUFFER_ERR_FLAGS_EN` defined: `overflow_err` and `underflow_err` are implemented as described.
- `BUFFER_ERR_FLAGS_EN` undefined:
  - Both error ports remain present and are tied to 0; no flag flops are built.
  - Drop and ignore behaviour on full and empty is unchanged.

## Test plan
- Reset then 4 AHB pushes 8'h11, 8'h22, 8'h33, 8'h44 -> occupancy 4. Four `get_rx_data` pops -> 11, 22, 33, 44 in order, occupancy 0, `buffer_empty` 1.
- 64 RX pushes of 0..63 -> `buffer_full` 1. 65th push dropped -> `overflow_err` 1. 64 TX pops -> 0..63, pointers wrapped to 0.
- Occupancy 5; simultaneous push 8'hAA and `get_rx_data` -> occupancy stays 5, and 8'hAA is read out 5th.
- Simultaneous `store_rx_packet_data` 8'h01 and `store_tx_data` 8'h02 -> only 8'h01 stored, occupancy +1, `overflow_err` 1 (flag suppressed when the macro is undefined).
- Occupancy 10, `clear` together with a push -> next cycle occupancy 0 and flags 0. A pop while empty -> `underflow_err` 1, `rx_data` 8'h00.
- Occupancy 30, `rst` pulsed between edges -> occupancy 0 and `buffer_empty` 1 before the next clock edge.
